// File: rtl/smi_pkg.sv
// Shared SMI constants, arbiter state encoding and round-robin pick helper.
package smi_pkg;

  localparam int unsigned SMI_EOFC_W        = 8;
  localparam int unsigned SMI_NUM_ARB_PORTS = 4;
  localparam int unsigned SMI_PORT_IDX_W    = 2;

  localparam logic [SMI_EOFC_W-1:0] SMI_EOFC_MID = 8'h00;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // First set bit of req searching upwards from (last+1) mod 4.
  function automatic logic [SMI_PORT_IDX_W-1:0] smi_rr_pick(
    input logic [SMI_NUM_ARB_PORTS-1:0] req,
    input logic [SMI_PORT_IDX_W-1:0]    last
  );
    logic [SMI_PORT_IDX_W-1:0] idx;
    smi_rr_pick = last;
    // Walk from farthest to nearest so the nearest requester wins.
    for (int k = SMI_NUM_ARB_PORTS; k >= 1; k--) begin
      idx = last + SMI_PORT_IDX_W'(k);
      if (req[idx]) begin
        smi_rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/smi_frame_arbiter_if.sv
// SMI arbiter bus: four requester lanes in, one arbitrated lane out, lock status.
interface smi_frame_arbiter_if #(
  parameter int unsigned DataIndexSize = 3,
  parameter int unsigned UserWidth     = 1
);
  import smi_pkg::*;

  localparam int unsigned DataWidth = (32'd1 << DataIndexSize) * 8;

  logic [SMI_NUM_ARB_PORTS-1:0]            smiInValid;
  logic [SMI_NUM_ARB_PORTS*DataWidth-1:0]  smiInData;
  logic [SMI_NUM_ARB_PORTS*SMI_EOFC_W-1:0] smiInEofc;
  logic [SMI_NUM_ARB_PORTS*UserWidth-1:0]  smiInUser;
  logic [SMI_NUM_ARB_PORTS-1:0]            smiInStop;
  logic                                    smiOutValid;
  logic [DataWidth-1:0]                    smiOutData;
  logic [SMI_EOFC_W-1:0]                   smiOutEofc;
  logic [UserWidth-1:0]                    smiOutUser;
  logic                                    smiOutStop;
  logic [SMI_PORT_IDX_W-1:0]               grantPort;
  logic                                    frameActive;

  // Environment side: drives requesters and downstream stop.
  modport master (
    output smiInValid, smiInData, smiInEofc, smiInUser, smiOutStop,
    input  smiInStop, smiOutValid, smiOutData, smiOutEofc, smiOutUser,
    input  grantPort, frameActive
  );

  // Arbiter side.
  modport slave (
    input  smiInValid, smiInData, smiInEofc, smiInUser, smiOutStop,
    output smiInStop, smiOutValid, smiOutData, smiOutEofc, smiOutUser,
    output grantPort, frameActive
  );

endinterface

// File: rtl/smi_frame_skid_buffer.sv
// Two-entry valid/stop register stage; upstream stop comes straight from occupancy.
module smi_frame_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_stop_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_stop_i
);

  logic [1:0]       count_q, count_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic             push, pop;

  assign in_stop_o   = (count_q == 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;
  assign push        = in_valid_i & ~in_stop_o;
  assign pop         = out_valid_o & ~out_stop_i;

  // Occupancy and entry update; head is always the output beat.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push && pop) begin
      // Push implies one entry at most, so the new beat replaces the head.
      head_d = in_data_i;
    end else if (pop) begin
      head_d  = tail_q;
      count_d = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_d = in_data_i;
      end else begin
        tail_d = in_data_i;
      end
      count_d = count_q + 2'd1;
    end
  end

  // Entry and occupancy registers; reset empties the stage.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/smi_frame_arbiter.sv
// Frame-atomic 4:1 round-robin SMI arbiter with a registered skid output stage.
module smi_frame_arbiter
  import smi_pkg::*;
#(
  parameter int unsigned DataIndexSize = 3,
  parameter int unsigned UserWidth     = 1
) (
  input  logic                clk,
  input  logic                arstn,
  smi_frame_arbiter_if.slave  bus
);

  localparam int unsigned DataWidth = (32'd1 << DataIndexSize) * 8;
  localparam int unsigned PayloadW  = DataWidth + SMI_EOFC_W + UserWidth;

  logic [0:0]                   state_q, state_d;
  logic [SMI_PORT_IDX_W-1:0]    grant_q, grant_d;
  logic [SMI_PORT_IDX_W-1:0]    last_q, last_d;
  logic                         active_q, active_d;

  logic                         sel_valid;
  logic [DataWidth-1:0]         sel_data;
  logic [SMI_EOFC_W-1:0]        sel_eofc;
  logic [UserWidth-1:0]         sel_user;
  logic                         buf_in_valid;
  logic                         buf_full;
  logic                         buf_out_valid;
  logic [PayloadW-1:0]          buf_out_data;
  logic                         final_fire;
  logic [SMI_NUM_ARB_PORTS-1:0] stop_c;

  // Select the granted requester's fields.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_eofc  = '0;
    sel_user  = '0;
    for (int n = 0; n < SMI_NUM_ARB_PORTS; n++) begin
      if (grant_q == SMI_PORT_IDX_W'(n)) begin
        sel_valid = bus.smiInValid[n];
        sel_data  = bus.smiInData[n*DataWidth +: DataWidth];
        sel_eofc  = bus.smiInEofc[n*SMI_EOFC_W +: SMI_EOFC_W];
        sel_user  = bus.smiInUser[n*UserWidth +: UserWidth];
      end
    end
  end

  assign buf_in_valid = (state_q == ST_LOCK) & sel_valid;
  assign final_fire   = buf_in_valid & ~buf_full & (sel_eofc != SMI_EOFC_MID);

  // Only the lock owner sees the buffer stop; everyone else is held off.
  always_comb begin
    stop_c = '1;
    if (state_q == ST_LOCK) begin
      stop_c[grant_q] = buf_full;
    end
  end

  // Arbitration FSM: grant in IDLE, hold until the final beat transfers.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    active_d = active_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.smiInValid) begin
          grant_d  = smi_rr_pick(bus.smiInValid, last_q);
          last_d   = grant_d;
          active_d = 1'b1;
          state_d  = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (final_fire) begin
          active_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        active_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // FSM, grant and pointer registers; pointer resets so port 0 goes first.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= SMI_PORT_IDX_W'(SMI_NUM_ARB_PORTS - 1);
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      active_q <= active_d;
    end
  end

  smi_frame_skid_buffer #(
    .Width (PayloadW)
  ) u_skid (
    .clk         (clk),
    .arstn       (arstn),
    .in_valid_i  (buf_in_valid),
    .in_data_i   ({sel_data, sel_eofc, sel_user}),
    .in_stop_o   (buf_full),
    .out_valid_o (buf_out_valid),
    .out_data_o  (buf_out_data),
    .out_stop_i  (bus.smiOutStop)
  );

  assign bus.smiInStop   = stop_c;
  assign bus.smiOutValid = buf_out_valid;
  assign bus.smiOutData  = buf_out_data[PayloadW-1 -: DataWidth];
  assign bus.smiOutEofc  = buf_out_data[UserWidth +: SMI_EOFC_W];
  assign bus.smiOutUser  = buf_out_data[UserWidth-1:0];
  assign bus.grantPort   = grant_q;
  assign bus.frameActive = active_q;

endmodule

// File: tb/tb_smi_frame_arbiter.sv
// Directed bench for smi_frame_arbiter: per-port beat tables, output capture, grant log.
module tb_smi_frame_arbiter;

  logic clk = 1'b0;
  logic arstn;

  smi_frame_arbiter_if #(.DataIndexSize(3), .UserWidth(1)) bus ();

  smi_frame_arbiter #(.DataIndexSize(3), .UserWidth(1)) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [63:0] tab_data [4][16];
  logic [7:0]  tab_eofc [4][16];
  int          tab_len  [4];
  int          tab_ptr  [4];
  logic [3:0]  en;
  logic        out_stop;
  logic [3:0]  fire;
  logic [3:0]  fin;

  logic [63:0] cap_data [64];
  logic [7:0]  cap_eofc [64];
  logic        cap_user [64];
  int          cap_n;
  logic [63:0] exp_data [64];
  logic [7:0]  exp_eofc [64];
  int          exp_n;
  logic [1:0]  glog [32];
  int          gn;
  logic        prev_active;

  function automatic logic [63:0] mk(input int port, input int frame, input int beat);
    return {8'(port), 40'h0, 8'(frame), 8'(beat)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int port, input int frame, input int nbeats, input logic [7:0] last_eofc);
    for (int b = 0; b < nbeats; b++) begin
      tab_data[port][tab_len[port]] = mk(port, frame, b);
      tab_eofc[port][tab_len[port]] = (b == nbeats - 1) ? last_eofc : 8'h00;
      tab_len[port]++;
    end
  endtask

  task automatic add_exp(input int port, input int frame, input int nbeats, input logic [7:0] last_eofc);
    for (int b = 0; b < nbeats; b++) begin
      exp_data[exp_n] = mk(port, frame, b);
      exp_eofc[exp_n] = (b == nbeats - 1) ? last_eofc : 8'h00;
      exp_n++;
    end
  endtask

  task automatic check_stream(input string tag);
    chk($sformatf("%s_count", tag), 64'(cap_n), 64'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), cap_data[i], exp_data[i]);
      chk($sformatf("%s_eofc%0d", tag, i), 64'(cap_eofc[i]), 64'(exp_eofc[i]));
      chk($sformatf("%s_user%0d", tag, i), 64'(cap_user[i]), 64'(exp_data[i][0]));
    end
  endtask

  task automatic clear_state();
    bus.smiInValid = '0;
    bus.smiInData  = '0;
    bus.smiInEofc  = '0;
    bus.smiInUser  = '0;
    bus.smiOutStop = 1'b0;
    en          = '0;
    out_stop    = 1'b0;
    fire        = '0;
    fin         = '0;
    cap_n       = 0;
    exp_n       = 0;
    gn          = 0;
    prev_active = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tab_len[n] = 0;
      tab_ptr[n] = 0;
    end
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    clear_state();
    #2;
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic all_done();
    for (int n = 0; n < 4; n++) begin
      if (tab_ptr[n] < tab_len[n]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: drive from tables, note transfers, step past the edge, log grants.
  task automatic run_cycle();
    for (int n = 0; n < 4; n++) begin
      if (en[n] && tab_ptr[n] < tab_len[n]) begin
        bus.smiInValid[n]          = 1'b1;
        bus.smiInData[n*64 +: 64]  = tab_data[n][tab_ptr[n]];
        bus.smiInEofc[n*8 +: 8]    = tab_eofc[n][tab_ptr[n]];
        bus.smiInUser[n]           = tab_data[n][tab_ptr[n]][0];
      end else begin
        bus.smiInValid[n]          = 1'b0;
        bus.smiInData[n*64 +: 64]  = '0;
        bus.smiInEofc[n*8 +: 8]    = '0;
        bus.smiInUser[n]           = 1'b0;
      end
    end
    bus.smiOutStop = out_stop;
    #1;
    for (int n = 0; n < 4; n++) begin
      fire[n] = bus.smiInValid[n] & ~bus.smiInStop[n];
    end
    if (bus.smiOutValid && !bus.smiOutStop && cap_n < 64) begin
      cap_data[cap_n] = bus.smiOutData;
      cap_eofc[cap_n] = bus.smiOutEofc;
      cap_user[cap_n] = bus.smiOutUser[0];
      cap_n++;
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      fin[n] = 1'b0;
      if (fire[n]) begin
        fin[n] = (tab_eofc[n][tab_ptr[n]] != 8'h00);
        tab_ptr[n]++;
      end
    end
    if (bus.frameActive && !prev_active && gn < 32) begin
      glog[gn] = bus.grantPort;
      gn++;
    end
    prev_active = bus.frameActive;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while reset is held.
    arstn = 1'b0;
    clear_state();
    @(posedge clk);
    #1;
    chk("rst_in_stop",  64'(bus.smiInStop), 64'hF);
    chk("rst_out_valid", 64'(bus.smiOutValid), 64'h0);
    chk("rst_out_data", bus.smiOutData, 64'h0);
    chk("rst_out_eofc", 64'(bus.smiOutEofc), 64'h0);
    chk("rst_out_user", 64'(bus.smiOutUser), 64'h0);
    chk("rst_grant",    64'(bus.grantPort), 64'h0);
    chk("rst_active",   64'(bus.frameActive), 64'h0);
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;

    // Port 2, 3-beat frame ending EOFC 5, output never stopped.
    clear_state();
    en = 4'b0100;
    add_frame(2, 0, 3, 8'd5);
    add_exp(2, 0, 3, 8'd5);
    for (int k = 0; k < 20 && !fin[2]; k++) run_cycle();
    chk("s1_final_seen", 64'(fin[2]), 64'h1);
    chk("s1_active_drop", 64'(bus.frameActive), 64'h0);
    chk("s1_grant_count", 64'(gn), 64'h1);
    chk("s1_grant_port", 64'(glog[0]), 64'h2);
    for (int k = 0; k < 3; k++) run_cycle();
    check_stream("s1");

    // All four ports busy with two 2-beat frames each.
    do_reset();
    en = 4'b1111;
    for (int p = 0; p < 4; p++) begin
      add_frame(p, 0, 2, 8'(p + 1));
      add_frame(p, 1, 2, 8'(p + 1));
    end
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 4; p++) add_exp(p, f, 2, 8'(p + 1));
    end
    for (int k = 0; k < 200 && !all_done(); k++) run_cycle();
    chk("s2_done", 64'(all_done()), 64'h1);
    for (int k = 0; k < 3; k++) run_cycle();
    chk("s2_grant_count", 64'(gn), 64'd8);
    chk("s2_grant0", 64'(glog[0]), 64'd0);
    chk("s2_grant1", 64'(glog[1]), 64'd1);
    chk("s2_grant2", 64'(glog[2]), 64'd2);
    chk("s2_grant3", 64'(glog[3]), 64'd3);
    chk("s2_grant4", 64'(glog[4]), 64'd0);
    check_stream("s2");

    // Port 1, 6-beat frame with the output stopped for 5 cycles.
    do_reset();
    en = 4'b0010;
    add_frame(1, 0, 6, 8'd3);
    add_exp(1, 0, 6, 8'd3);
    for (int c = 0; c < 30; c++) begin
      out_stop = (c >= 2 && c <= 6);
      run_cycle();
      if (c == 1) begin
        chk("s3_stop_one_buffered", 64'(bus.smiInStop), 64'hD);
        chk("s3_out_valid", 64'(bus.smiOutValid), 64'h1);
      end
      if (c == 2) chk("s3_stop_two_buffered", 64'(bus.smiInStop), 64'hF);
      if (c == 5) begin
        chk("s3_stop_stalled", 64'(bus.smiInStop), 64'hF);
        chk("s3_head_held", bus.smiOutData, mk(1, 0, 0));
      end
    end
    chk("s3_active_end", 64'(bus.frameActive), 64'h0);
    check_stream("s3");

    // Port 3 finishing with last=3 while port 1 requests: port 1 next, 1-cycle gap.
    do_reset();
    add_frame(3, 0, 2, 8'd9);
    add_frame(1, 0, 1, 8'd1);
    en = 4'b1000;
    run_cycle();
    chk("s4a_grant3", 64'(bus.grantPort), 64'd3);
    en = 4'b1010;
    for (int k = 0; k < 20 && !fin[3]; k++) run_cycle();
    chk("s4a_final_seen", 64'(fin[3]), 64'h1);
    chk("s4a_gap_active", 64'(bus.frameActive), 64'h0);
    chk("s4a_gap_stop", 64'(bus.smiInStop), 64'hF);
    run_cycle();
    chk("s4a_regrant_active", 64'(bus.frameActive), 64'h1);
    chk("s4a_regrant_port", 64'(bus.grantPort), 64'd1);

    // Same, with port 0 also requesting: port 0 wins.
    do_reset();
    add_frame(3, 0, 2, 8'd9);
    add_frame(1, 0, 1, 8'd1);
    add_frame(0, 0, 1, 8'd1);
    en = 4'b1000;
    run_cycle();
    en = 4'b1011;
    for (int k = 0; k < 20 && !fin[3]; k++) run_cycle();
    chk("s4b_final_seen", 64'(fin[3]), 64'h1);
    chk("s4b_gap_active", 64'(bus.frameActive), 64'h0);
    run_cycle();
    chk("s4b_regrant_active", 64'(bus.frameActive), 64'h1);
    chk("s4b_regrant_port", 64'(bus.grantPort), 64'd0);

    // Port 0 single-beat frames back to back; last one carries EOFC above 8.
    do_reset();
    en = 4'b0001;
    add_frame(0, 0, 1, 8'd8);
    add_frame(0, 1, 1, 8'd8);
    add_frame(0, 2, 1, 8'd8);
    add_frame(0, 3, 1, 8'hF0);
    add_exp(0, 0, 1, 8'd8);
    add_exp(0, 1, 1, 8'd8);
    add_exp(0, 2, 1, 8'd8);
    add_exp(0, 3, 1, 8'hF0);
    for (int k = 0; k < 8; k++) begin
      run_cycle();
      chk($sformatf("s5_active%0d", k), 64'(bus.frameActive), (k % 2 == 0) ? 64'h1 : 64'h0);
      if (k % 2 == 0) chk($sformatf("s5_grant%0d", k), 64'(bus.grantPort), 64'd0);
    end
    for (int k = 0; k < 2; k++) run_cycle();
    check_stream("s5");

    // Reset after two beats of a 4-beat frame on port 1 with the output stopped.
    do_reset();
    out_stop = 1'b1;
    en = 4'b0010;
    add_frame(1, 0, 4, 8'd4);
    for (int k = 0; k < 20 && tab_ptr[1] < 2; k++) run_cycle();
    chk("s6_two_beats_in", 64'(tab_ptr[1]), 64'd2);
    chk("s6_pre_out_valid", 64'(bus.smiOutValid), 64'h1);
    arstn = 1'b0;
    #1;
    chk("s6_async_out_valid", 64'(bus.smiOutValid), 64'h0);
    chk("s6_async_in_stop", 64'(bus.smiInStop), 64'hF);
    chk("s6_async_active", 64'(bus.frameActive), 64'h0);
    chk("s6_async_out_data", bus.smiOutData, 64'h0);
    clear_state();
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    chk("s6_post_empty", 64'(bus.smiOutValid), 64'h0);
    for (int p = 0; p < 4; p++) add_frame(p, 1, 1, 8'd1);
    en = 4'b1111;
    run_cycle();
    chk("s6_first_grant", 64'(bus.grantPort), 64'd0);
    chk("s6_first_active", 64'(bus.frameActive), 64'h1);
    for (int k = 0; k < 2; k++) run_cycle();
    chk("s6_first_beat", cap_data[0], mk(0, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
